// File: rtl/pwalk_mem_port_if.sv
// Walker request/response and L1 read-port signals between the page-table walker
// environment and the memory-side responder.
interface pwalk_mem_port_if;
  logic         except;
  logic         req_bus;
  logic         mOp_en;
  logic [8:0]   mOp_register;
  logic [35:0]  mOp_addrEven;
  logic [35:0]  mOp_addrOdd;
  logic [4:0]   mOp_bank0;
  logic         mOp_odd;
  logic         bus_hold;
  logic         cache_req;
  logic [39:0]  cache_addr;
  logic         cache_gnt;
  logic         cache_rsp_vld;
  logic         cache_rsp_hit;
  logic [127:0] cache_rsp_data;
  logic         FUHit;
  logic [8:0]   FUreg;
  logic [127:0] data_out;

  modport master (
    output except, req_bus, mOp_en, mOp_register, mOp_addrEven, mOp_addrOdd,
           mOp_bank0, mOp_odd, cache_gnt, cache_rsp_vld, cache_rsp_hit, cache_rsp_data,
    input  bus_hold, cache_req, cache_addr, FUHit, FUreg, data_out
  );

  modport slave (
    input  except, req_bus, mOp_en, mOp_register, mOp_addrEven, mOp_addrOdd,
           mOp_bank0, mOp_odd, cache_gnt, cache_rsp_vld, cache_rsp_hit, cache_rsp_data,
    output bus_hold, cache_req, cache_addr, FUHit, FUreg, data_out
  );
endinterface

// File: rtl/pwalk_mem_port.sv
// Memory-side responder for page-table walker reads: one outstanding read, forwarded to
// the L1 read port with miss backoff/retry, answered with a one-cycle FUHit strobe.
module pwalk_mem_port #(
  parameter logic [8:0] WALK_REG  = 9'h1fc,
  parameter int         RETRY_DLY = 4,
  parameter int         MAX_RETRY = 8
) (
  input  logic             clk,
  input  logic             rst,
  pwalk_mem_port_if.slave  bus
);

  localparam logic [3:0] RETRY_DLY_C = 4'(RETRY_DLY);
  localparam logic [3:0] MAX_RETRY_C = 4'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, BACKOFF, RESP} state_t;

  state_t      state;
  state_t      state_n;
  logic [3:0]  retry_cnt;
  logic [3:0]  retry_nxt;
  logic [3:0]  bo_cnt;
  logic        drop_pend;
  logic [8:0]  tag_q;
  logic        accept;
  logic        abort_inflight;
  logic [43:0] pa;

  assign pa = {bus.mOp_odd ? bus.mOp_addrOdd : bus.mOp_addrEven,
               bus.mOp_odd, bus.mOp_bank0, 2'b00};
  assign retry_nxt = retry_cnt + 4'd1;

  assign accept = (state == IDLE) && bus.req_bus && bus.mOp_en &&
                  (bus.mOp_register == WALK_REG) && !bus.except && !drop_pend;

  // A read the cache has already taken must have its response swallowed later; a
  // response arriving in the abort cycle itself is the one we would have waited for.
  assign abort_inflight = bus.except &&
                          (((state == WAIT) && !bus.cache_rsp_vld) ||
                           ((state == REQ) && bus.cache_gnt));

  assign bus.cache_req = (state == REQ);
  assign bus.FUHit     = (state == RESP);
  assign bus.bus_hold  = (state != IDLE) || drop_pend;

  always_comb begin
    state_n = state;
    if (bus.except) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_n = REQ;
        REQ:     if (bus.cache_gnt) state_n = WAIT;
        WAIT: begin
          if (bus.cache_rsp_vld) begin
            if (bus.cache_rsp_hit || (retry_nxt == MAX_RETRY_C)) state_n = RESP;
            else                                                   state_n = BACKOFF;
          end
        end
        BACKOFF: if (bo_cnt == 4'd1) state_n = REQ;
        RESP:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      retry_cnt      <= 4'd0;
      bo_cnt         <= 4'd0;
      drop_pend      <= 1'b0;
      tag_q          <= 9'd0;
      bus.cache_addr <= 40'd0;
      bus.FUreg      <= 9'd0;
      bus.data_out   <= 128'd0;
    end else begin
      state <= state_n;
      if (drop_pend && bus.cache_rsp_vld) drop_pend <= 1'b0;
      else if (abort_inflight)            drop_pend <= 1'b1;

      if (bus.except) begin
        retry_cnt <= 4'd0;
        bo_cnt    <= 4'd0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              bus.cache_addr <= pa[43:4];
              tag_q          <= bus.mOp_register;
              retry_cnt      <= 4'd0;
            end
          end
          WAIT: begin
            if (bus.cache_rsp_vld) begin
              if (bus.cache_rsp_hit) begin
                bus.data_out <= bus.cache_rsp_data;
                bus.FUreg    <= tag_q;
              end else begin
                retry_cnt <= retry_nxt;
                // Exhausted retries answer with zero data so the walker faults the page.
                if (retry_nxt == MAX_RETRY_C) begin
                  bus.data_out <= 128'd0;
                  bus.FUreg    <= tag_q;
                end else begin
                  bo_cnt <= RETRY_DLY_C;
                end
              end
            end
          end
          BACKOFF: bo_cnt <= bo_cnt - 4'd1;
          default: ;
        endcase
      end
    end
  end

  stray_rsp_chk: assert property (@(posedge clk) disable iff (rst)
    bus.cache_rsp_vld |-> ((state == WAIT) || drop_pend));

endmodule

// File: tb/tb_pwalk_mem_port.sv
// Self-checking bench for pwalk_mem_port: an L1 responder with scripted grant/response
// delays and miss counts, checked against walk outcomes computed from the protocol rules.
module tb_pwalk_mem_port;
  localparam logic [8:0] WALK_REG  = 9'h1fc;
  localparam int         RETRY_DLY = 4;
  localparam int         MAX_RETRY = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  pwalk_mem_port_if bus ();

  pwalk_mem_port #(.WALK_REG(WALK_REG), .RETRY_DLY(RETRY_DLY), .MAX_RETRY(MAX_RETRY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int           obs_grants, obs_fuhit, obs_fuhit_cyc, obs_gap_bad;
  logic         obs_hold_first, obs_hold_after, obs_timeout;
  logic [8:0]   obs_reg;
  logic [127:0] obs_data;
  logic [39:0]  obs_addr;

  function automatic logic [39:0] model_addr(input logic [35:0] ae, input logic [35:0] ao,
                                             input logic [4:0] bank, input logic odd);
    logic [43:0] pa;
    pa = {odd ? ao : ae, odd, bank, 2'b00};
    return pa[43:4];
  endfunction

  task automatic clear_inputs();
    bus.except = 0; bus.req_bus = 0; bus.mOp_en = 0; bus.mOp_register = 0;
    bus.mOp_addrEven = 0; bus.mOp_addrOdd = 0; bus.mOp_bank0 = 0; bus.mOp_odd = 0;
    bus.cache_gnt = 0; bus.cache_rsp_vld = 0; bus.cache_rsp_hit = 0; bus.cache_rsp_data = 0;
  endtask

  // Presents one request for a single cycle; returns at the negedge of the cycle after it.
  task automatic issue_req(input logic [35:0] ae, input logic [35:0] ao, input logic [4:0] bank,
                           input logic odd, input logic [8:0] tag, input logic en);
    @(negedge clk);
    bus.mOp_addrEven = ae; bus.mOp_addrOdd = ao; bus.mOp_bank0 = bank; bus.mOp_odd = odd;
    bus.mOp_register = tag; bus.mOp_en = en; bus.req_bus = 1'b1;
    @(negedge clk);
    bus.req_bus = 1'b0; bus.mOp_en = 1'b0;
  endtask

  // Plays the L1 cache for one walk: grants after gnt_dly cycles of cache_req, answers
  // rsp_dly cycles into WAIT, misses the first n_miss attempts. Cycle 1 = cycle after accept.
  task automatic serve(input int gnt_dly, input int rsp_dly, input int n_miss,
                       input logic [127:0] data);
    int cyc = 1, held = 0, attempt = 0, rsp_at = -1, miss_cyc = -1;
    bit done = 0, after = 0, hit;
    obs_grants = 0; obs_fuhit = 0; obs_fuhit_cyc = -1; obs_gap_bad = 0;
    obs_reg = 'x; obs_data = 'x; obs_addr = 'x; obs_hold_after = 'x; obs_timeout = 0;
    obs_hold_first = bus.bus_hold;
    while (!after && cyc < 400) begin
      bus.cache_gnt = 0; bus.cache_rsp_vld = 0; bus.cache_rsp_hit = 0;
      if (done) begin
        obs_hold_after = bus.bus_hold;
        after = 1;
      end
      if (bus.FUHit) begin
        obs_fuhit++;
        if (!done) begin
          obs_fuhit_cyc = cyc; obs_reg = bus.FUreg; obs_data = bus.data_out; done = 1;
        end
      end
      if (bus.cache_req) begin
        if (attempt == 0 && held == 0) obs_addr = bus.cache_addr;
        if (miss_cyc >= 0) begin
          if (cyc - miss_cyc - 1 != RETRY_DLY) obs_gap_bad++;
          miss_cyc = -1;
        end
        if (held == gnt_dly) begin
          bus.cache_gnt = 1; obs_grants++; attempt++; held = 0; rsp_at = cyc + 1 + rsp_dly;
        end else begin
          held++;
        end
      end
      if (cyc == rsp_at) begin
        hit = (attempt > n_miss);
        bus.cache_rsp_vld = 1; bus.cache_rsp_hit = hit;
        bus.cache_rsp_data = hit ? data : {$urandom, $urandom, $urandom, $urandom};
        rsp_at = -1;
        if (!hit) miss_cyc = cyc;
      end
      if (!after) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!after) obs_timeout = 1;
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tests++; if (bus.bus_hold !== 1'b0) begin fails++; $display("[TB] FAIL reset_hold: got %0b expected 0", bus.bus_hold); end
    tests++; if (bus.cache_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_req: got %0b expected 0", bus.cache_req); end
    tests++; if (bus.FUHit !== 1'b0) begin fails++; $display("[TB] FAIL reset_fuhit: got %0b expected 0", bus.FUHit); end
    tests++; if (bus.FUreg !== 9'd0) begin fails++; $display("[TB] FAIL reset_fureg: got %0h expected 0", bus.FUreg); end
    tests++; if (bus.data_out !== 128'd0) begin fails++; $display("[TB] FAIL reset_data: got %0h expected 0", bus.data_out); end
    tests++; if (bus.cache_addr !== 40'd0) begin fails++; $display("[TB] FAIL reset_addr: got %0h expected 0", bus.cache_addr); end
  endtask

  task automatic test_basic();
    logic [127:0] d = {4{32'hA5A5A5A5}};
    issue_req(36'h123456789, 36'hfedcba987, 5'h0a, 1'b0, WALK_REG, 1'b1);
    serve(0, 0, 0, d);
    tests++; if (obs_addr !== 40'h1234567892) begin fails++; $display("[TB] FAIL basic_addr: got %0h expected 1234567892", obs_addr); end
    tests++; if (obs_hold_first !== 1'b1) begin fails++; $display("[TB] FAIL basic_hold_on: got %0b expected 1", obs_hold_first); end
    tests++; if (obs_fuhit_cyc !== 3) begin fails++; $display("[TB] FAIL basic_latency: got %0d expected 3", obs_fuhit_cyc); end
    tests++; if (obs_fuhit !== 1) begin fails++; $display("[TB] FAIL basic_strobes: got %0d expected 1", obs_fuhit); end
    tests++; if (obs_reg !== WALK_REG) begin fails++; $display("[TB] FAIL basic_fureg: got %0h expected %0h", obs_reg, WALK_REG); end
    tests++; if (obs_data !== d) begin fails++; $display("[TB] FAIL basic_data: got %0h expected %0h", obs_data, d); end
    tests++; if (obs_hold_after !== 1'b0) begin fails++; $display("[TB] FAIL basic_hold_off: got %0b expected 0", obs_hold_after); end
  endtask

  task automatic test_ignored();
    issue_req(36'h111111111, 36'h222222222, 5'h03, 1'b1, 9'h1f0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tests++; if (bus.cache_req !== 1'b0 || bus.bus_hold !== 1'b0) begin fails++; $display("[TB] FAIL bad_tag: req/hold got %0b%0b expected 00", bus.cache_req, bus.bus_hold); end
      @(negedge clk);
    end
    issue_req(36'h111111111, 36'h222222222, 5'h03, 1'b1, WALK_REG, 1'b0);
    tests++; if (bus.cache_req !== 1'b0 || bus.bus_hold !== 1'b0) begin fails++; $display("[TB] FAIL en_low: req/hold got %0b%0b expected 00", bus.cache_req, bus.bus_hold); end
  endtask

  task automatic test_retry();
    logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
    issue_req(36'h0abcdef01, 36'h0, 5'h1f, 1'b0, WALK_REG, 1'b1);
    serve(0, 0, 2, d);
    tests++; if (obs_grants !== 3) begin fails++; $display("[TB] FAIL retry_grants: got %0d expected 3", obs_grants); end
    tests++; if (obs_gap_bad !== 0) begin fails++; $display("[TB] FAIL retry_backoff: got %0d bad gaps expected 0", obs_gap_bad); end
    tests++; if (obs_fuhit !== 1 || obs_data !== d) begin fails++; $display("[TB] FAIL retry_data: got %0d strobes data %0h expected 1 and %0h", obs_fuhit, obs_data, d); end
    tests++; if (obs_fuhit_cyc !== 1 + 3 * 2 + 2 * RETRY_DLY) begin fails++; $display("[TB] FAIL retry_latency: got %0d expected %0d", obs_fuhit_cyc, 1 + 3 * 2 + 2 * RETRY_DLY); end
  endtask

  task automatic test_max_retry();
    issue_req(36'h055555555, 36'h0aaaaaaaa, 5'h10, 1'b1, WALK_REG, 1'b1);
    serve(0, 0, 100, {4{32'hdeadbeef}});
    tests++; if (obs_grants !== MAX_RETRY) begin fails++; $display("[TB] FAIL max_grants: got %0d expected %0d", obs_grants, MAX_RETRY); end
    tests++; if (obs_fuhit !== 1 || obs_data !== 128'd0) begin fails++; $display("[TB] FAIL max_data: got %0d strobes data %0h expected 1 and 0", obs_fuhit, obs_data); end
    tests++; if (obs_timeout !== 1'b0) begin fails++; $display("[TB] FAIL max_timeout: got %0b expected 0", obs_timeout); end
  endtask

  task automatic test_except_wait();
    logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
    int bad = 0;
    issue_req(36'h0cafe0001, 36'h0, 5'h04, 1'b0, WALK_REG, 1'b1);
    bus.cache_gnt = bus.cache_req;
    @(negedge clk);
    bus.cache_gnt = 0; bus.except = 1;
    @(negedge clk);
    bus.except = 0;
    for (int c = 3; c <= 7; c++) begin
      if (bus.FUHit !== 1'b0 || bus.bus_hold !== 1'b1 || bus.cache_req !== 1'b0) bad++;
      bus.req_bus = (c == 3); bus.mOp_en = (c == 3); bus.mOp_register = WALK_REG;
      if (c == 7) begin
        bus.cache_rsp_vld = 1; bus.cache_rsp_hit = 1; bus.cache_rsp_data = ~d;
      end
      @(negedge clk);
      bus.req_bus = 0; bus.mOp_en = 0;
    end
    clear_inputs();
    tests++; if (bad !== 0) begin fails++; $display("[TB] FAIL abort_hold: got %0d bad cycles expected 0", bad); end
    tests++; if (bus.bus_hold !== 1'b0 || bus.FUHit !== 1'b0) begin fails++; $display("[TB] FAIL abort_release: hold/fuhit got %0b%0b expected 00", bus.bus_hold, bus.FUHit); end
    issue_req(36'h0beef0002, 36'h0, 5'h08, 1'b0, WALK_REG, 1'b1);
    serve(1, 2, 0, d);
    tests++; if (obs_fuhit !== 1 || obs_data !== d) begin fails++; $display("[TB] FAIL abort_next: got %0d strobes data %0h expected 1 and %0h", obs_fuhit, obs_data, d); end
  endtask

  task automatic test_except_req();
    logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
    issue_req(36'h012121212, 36'h0, 5'h02, 1'b0, WALK_REG, 1'b1);
    @(negedge clk);
    @(negedge clk);
    tests++; if (bus.cache_req !== 1'b1) begin fails++; $display("[TB] FAIL req_held: got %0b expected 1", bus.cache_req); end
    bus.except = 1;
    @(negedge clk);
    bus.except = 0;
    tests++; if (bus.cache_req !== 1'b0 || bus.bus_hold !== 1'b0) begin fails++; $display("[TB] FAIL req_abort: req/hold got %0b%0b expected 00", bus.cache_req, bus.bus_hold); end
    @(negedge clk);
    bus.req_bus = 1; bus.mOp_en = 1; bus.mOp_register = WALK_REG; bus.except = 1;
    @(negedge clk);
    clear_inputs();
    tests++; if (bus.cache_req !== 1'b0 || bus.bus_hold !== 1'b0) begin fails++; $display("[TB] FAIL except_accept: req/hold got %0b%0b expected 00", bus.cache_req, bus.bus_hold); end
    issue_req(36'h034343434, 36'h0, 5'h06, 1'b0, WALK_REG, 1'b1);
    serve(0, 1, 0, d);
    tests++; if (obs_fuhit !== 1 || obs_data !== d) begin fails++; $display("[TB] FAIL req_abort_next: got %0d strobes data %0h expected 1 and %0h", obs_fuhit, obs_data, d); end
  endtask

  task automatic test_random();
    logic [63:0]  r1, r2;
    logic [35:0]  ae, ao;
    logic [4:0]   bank;
    logic         odd;
    logic [127:0] d, exp_data;
    int gd, rd, nm, att, exp_cyc;
    for (int i = 0; i < 16; i++) begin
      r1 = {$urandom, $urandom}; r2 = {$urandom, $urandom};
      ae = r1[35:0]; ao = r2[35:0]; bank = 5'($urandom_range(0, 31)); odd = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom, $urandom, $urandom};
      gd = $urandom_range(0, 3); rd = $urandom_range(0, 3); nm = $urandom_range(0, MAX_RETRY + 1);
      att = (nm < MAX_RETRY) ? nm + 1 : MAX_RETRY;
      exp_data = (nm < MAX_RETRY) ? d : 128'd0;
      exp_cyc = 1 + att * (gd + rd + 2) + (att - 1) * RETRY_DLY;
      issue_req(ae, ao, bank, odd, WALK_REG, 1'b1);
      serve(gd, rd, nm, d);
      tests++; if (obs_addr !== model_addr(ae, ao, bank, odd)) begin fails++; $display("[TB] FAIL rnd%0d_addr: got %0h expected %0h", i, obs_addr, model_addr(ae, ao, bank, odd)); end
      tests++; if (obs_grants !== att) begin fails++; $display("[TB] FAIL rnd%0d_grants: got %0d expected %0d", i, obs_grants, att); end
      tests++; if (obs_fuhit !== 1 || obs_data !== exp_data || obs_reg !== WALK_REG) begin fails++; $display("[TB] FAIL rnd%0d_resp: got %0d strobes tag %0h data %0h expected 1 %0h %0h", i, obs_fuhit, obs_reg, obs_data, WALK_REG, exp_data); end
      tests++; if (obs_fuhit_cyc !== exp_cyc) begin fails++; $display("[TB] FAIL rnd%0d_latency: got %0d expected %0d", i, obs_fuhit_cyc, exp_cyc); end
      tests++; if (obs_gap_bad !== 0 || obs_hold_first !== 1'b1 || obs_hold_after !== 1'b0) begin fails++; $display("[TB] FAIL rnd%0d_timing: got gaps %0d hold %0b/%0b expected 0 1/0", i, obs_gap_bad, obs_hold_first, obs_hold_after); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignored();
    test_retry();
    test_max_retry();
    test_except_wait();
    test_except_req();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
